// File: rtl/bus_memory.sv
// bus_memory: boot-loading IMEM/DMEM responder with LED and cycle-counter I/O (counter under BUS_MEMORY_CYCLE_CNT_EN)
module bus_memory #(
  parameter int AW = 8
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] IA,
  output logic [15:0] ID,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  input  logic [15:0] LD_DATA,
  input  logic        LD_VALID,
  input  logic        LD_LAST,
  output logic        LD_READY,
  output logic        CPU_RST,
  output logic [15:0] LED,
  output logic        LOAD_ERR
);
  typedef enum logic [1:0] {INIT, LOAD, HOLD, RUN} state_t;
  state_t      state;
  logic [AW:0] ptr;
  logic [15:0] imem [2**AW];
  logic [15:0] dmem [2**AW];
  logic [15:0] cnt_val;
  logic [15:0] rdata;
  logic        unused_bits;
  assign unused_bits = ^{IA[15:AW]};
  always_ff @(posedge CK or negedge RST)
    if (!RST) begin
      state    <= INIT;
      ptr      <= '0;
      CPU_RST  <= 1'b1;
      LD_READY <= 1'b0;
      LED      <= '0;
      LOAD_ERR <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state    <= LOAD;
          LD_READY <= 1'b1;
        end
        LOAD: if (LD_VALID) begin
          if (ptr[AW]) LOAD_ERR <= 1'b1;
          else ptr <= ptr + 1'b1;
          if (LD_LAST) begin
            state    <= HOLD;
            LD_READY <= 1'b0;
          end
        end
        HOLD: begin
          state   <= RUN;
          CPU_RST <= 1'b0;
        end
        RUN: if (!RW && DA == 16'hFFFF) LED <= DD;
        default: state <= INIT;
      endcase
    end
`ifdef BUS_MEMORY_CYCLE_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge CK or negedge RST)
    if (!RST) cnt <= '0;
    else if (state == HOLD) cnt <= '0;
    else if (state == RUN) cnt <= cnt + 16'd1;
  assign cnt_val = cnt;
`else
  assign cnt_val = '0;
`endif
  // Memory arrays are deliberately left out of reset so a reset keeps contents.
  always_ff @(posedge CK) begin
    if (state == LOAD && LD_VALID && !ptr[AW]) imem[ptr[AW-1:0]] <= LD_DATA;
    if (state == RUN && !RW && DA[15:1] != 15'h7FFF) dmem[DA[AW-1:0]] <= DD;
  end
  assign ID    = imem[IA[AW-1:0]];
  assign rdata = DA == 16'hFFFF ? LED : DA == 16'hFFFE ? cnt_val : dmem[DA[AW-1:0]];
  assign DD    = (RW && state == RUN) ? rdata : 16'hzzzz;
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: directed checks of boot load, data port, I/O words, overflow and mid-load reset
module tb_bus_memory;
  logic        ck = 1'b0;
  logic        rst;
  logic [15:0] ia, da, ld_data, dd_drv;
  logic        rw, ld_valid, ld_last, dd_en;
  wire  [15:0] dd;
  logic [15:0] id, led;
  logic        ld_ready, cpu_rst, load_err;
  logic [15:0] s_ia, s_da, s_ld_data, s_id, s_led;
  logic        s_ld_valid, s_ld_last, s_ld_ready, s_cpu_rst, s_load_err;
  wire  [15:0] s_dd;
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  bit          in_run = 1'b0;
  assign dd = dd_en ? dd_drv : 16'hzzzz;
  always #5 ck = ~ck;
  bus_memory #(.AW(8)) u_dut (
    .CK(ck), .RST(rst), .IA(ia), .ID(id), .DA(da), .DD(dd), .RW(rw),
    .LD_DATA(ld_data), .LD_VALID(ld_valid), .LD_LAST(ld_last), .LD_READY(ld_ready),
    .CPU_RST(cpu_rst), .LED(led), .LOAD_ERR(load_err)
  );
  bus_memory #(.AW(2)) u_small (
    .CK(ck), .RST(rst), .IA(s_ia), .ID(s_id), .DA(s_da), .DD(s_dd), .RW(1'b1),
    .LD_DATA(s_ld_data), .LD_VALID(s_ld_valid), .LD_LAST(s_ld_last), .LD_READY(s_ld_ready),
    .CPU_RST(s_cpu_rst), .LED(s_led), .LOAD_ERR(s_load_err)
  );
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge ck);
    #1;
    if (in_run) exp_cnt++;
  endtask
  task automatic load_word(input logic [15:0] d, input logic last);
    ld_data = d; ld_valid = 1'b1; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask
  function automatic logic [15:0] cnt_exp();
`ifdef BUS_MEMORY_CYCLE_CNT_EN
    return exp_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction
  initial begin
    rst = 1'b0; ia = '0; da = '0; rw = 1'b0; ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
    dd_drv = '0; dd_en = 1'b0;
    s_ia = '0; s_da = '0; s_ld_data = '0; s_ld_valid = 1'b0; s_ld_last = 1'b0;
    repeat (3) step();
    check("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("rst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("rst_led", led, 16'h0000);
    check("rst_load_err", {15'd0, load_err}, 16'd0);
    rst = 1'b1;
    step();
    check("ready_after_release", {15'd0, ld_ready}, 16'd1);
    check("small_ready_after_release", {15'd0, s_ld_ready}, 16'd1);
    load_word(16'h1001, 1'b0);
    load_word(16'h2002, 1'b0);
    check("cpu_rst_in_load", {15'd0, cpu_rst}, 16'd1);
    load_word(16'h3003, 1'b1);
    check("hold_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("hold_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    step();
    check("run_cpu_rst", {15'd0, cpu_rst}, 16'd0);
    in_run = 1'b1; exp_cnt = 0;
    rw = 1'b1; da = 16'hFFFE;
    repeat (10) step();
    check("cnt_after_10", dd, cnt_exp());
`ifdef BUS_MEMORY_CYCLE_CNT_EN
    repeat (65536) step();
    check("cnt_after_wrap", dd, 16'd10);
`endif
    for (int i = 0; i < 3; i++) begin
      ia = 16'(i); #1;
      check("id_read", id, 16'h1001 * 16'(i + 1));
    end
    rw = 1'b0; da = 16'h0005; dd_drv = 16'hBEEF; dd_en = 1'b1;
    #1 check("dd_released_on_store", dd, 16'hBEEF);
    step(); step();
    dd_en = 1'b0; rw = 1'b1; da = 16'h0105;
    #1 check("dmem_alias_read", dd, 16'hBEEF);
    rw = 1'b0; da = 16'h0006; dd_drv = 16'h1111; dd_en = 1'b1;
    step();
    dd_en = 1'b0; rw = 1'b1;
    #1 check("dmem_next_read", dd, 16'h1111);
    da = 16'h0005;
    #1 check("dmem_neighbour", dd, 16'hBEEF);
    rw = 1'b0; da = 16'hFFFF; dd_drv = 16'h00A5; dd_en = 1'b1;
    step();
    check("led_after_store", led, 16'h00A5);
    dd_en = 1'b0; rw = 1'b1;
    #1 check("led_read", dd, 16'h00A5);
    rw = 1'b0; da = 16'hFFFE; dd_drv = 16'h1234; dd_en = 1'b1;
    step();
    dd_en = 1'b0; rw = 1'b1;
    #1 check("cnt_ignores_store", dd, cnt_exp());
    check("led_kept", led, 16'h00A5);
    rw = 1'b0; ld_data = 16'hDEAD; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0; ia = 16'h0000;
    #1 check("valid_in_run_ignored", id, 16'h1001);
    check("valid_in_run_no_err", {15'd0, load_err}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      s_ld_data = 16'hA1 + 16'(i); s_ld_valid = 1'b1; s_ld_last = (i == 5);
      step();
      if (i == 3) check("small_no_err_at_4", {15'd0, s_load_err}, 16'd0);
      if (i == 4) check("small_err_at_5", {15'd0, s_load_err}, 16'd1);
    end
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
    step();
    check("small_run", {15'd0, s_cpu_rst}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      s_ia = 16'(i); #1;
      check("small_imem", s_id, 16'hA1 + 16'(i));
    end
    rst = 1'b0; #1 rst = 1'b1; in_run = 1'b0;
    step();
    load_word(16'h5555, 1'b0);
    load_word(16'h6666, 1'b0);
    #2 rst = 1'b0;
    #1 check("midload_ld_ready", {15'd0, ld_ready}, 16'd0);
    check("midload_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("midload_led", led, 16'h0000);
    rst = 1'b1;
    step();
    check("reload_ready", {15'd0, ld_ready}, 16'd1);
    load_word(16'h7777, 1'b1);
    ia = 16'h0000;
    #1 check("reload_word0", id, 16'h7777);
    ia = 16'h0001;
    #1 check("reload_retained", id, 16'h6666);
    step();
    check("reload_run", {15'd0, cpu_rst}, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
